regfile_wb_arbiter: RTL

- Shares the register file's single write port (reg_write / write_reg / write_data) among N writeback requesters, e.g. ALU, load unit and multiplier.
- Arbitrates one writer per cycle and registers the selected write toward the register file.
- Holds a 16-entry pending-write scoreboard so decode can detect RAW/WAW hazards on in-flight destinations.
- Sits between the execute-side units and the register file.

---
 rtl/regfile_wb_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback port arbiter with pending-write scoreboard.
// Define WB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer state).
module regfile_wb_arbiter #(
  parameter int N  = 3,
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*RW-1:0] req_reg,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    grant,
  output logic            reg_write,
  output logic [RW-1:0]   write_reg,
  output logic [DW-1:0]   write_data,
  input  logic            issue_valid,
  input  logic [RW-1:0]   issue_reg,
  input  logic [RW-1:0]   chk_reg1,
  input  logic [RW-1:0]   chk_reg2,
  output logic            busy1,
  output logic            busy2,
  output logic            issue_stall
);
  localparam int PW = $clog2(N);
  localparam int NR = 1 << RW;
  logic [PW-1:0] w_base;
  logic [N-1:0]  w_hi;
  logic [N-1:0]  w_v;
  logic [RW-1:0] w_reg;
  logic [DW-1:0] w_data;
  logic [NR-1:0] w_set;
  logic [NR-1:0] w_clr;
  logic [NR-1:0] r_pend;
`ifdef WB_FIXED_PRIO_EN
  assign w_base = '0;
`else
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_nxt;
  assign w_base = r_ptr;
`endif
  // requests at or above the base win first; otherwise wrap to the lowest index
  assign w_hi  = req & ~((N'(1) << w_base) - N'(1));
  assign w_v   = |w_hi ? w_hi : req;
  assign grant = w_v & (~w_v + N'(1));
  always_comb begin
    w_reg  = '0;
    w_data = '0;
`ifndef WB_FIXED_PRIO_EN
    w_nxt  = r_ptr;
`endif
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        w_reg  = req_reg[i*RW +: RW];
        w_data = req_data[i*DW +: DW];
`ifndef WB_FIXED_PRIO_EN
        w_nxt  = (i == N - 1) ? '0 : PW'(i + 1);
`endif
      end
    end
  end
  assign issue_stall = issue_valid & r_pend[issue_reg];
  assign busy1       = r_pend[chk_reg1];
  assign busy2       = r_pend[chk_reg2];
  assign w_set       = (issue_valid && !issue_stall) ? NR'(1) << issue_reg : '0;
  assign w_clr       = |grant ? NR'(1) << w_reg : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      r_pend     <= '0;
    end else begin
      reg_write <= |grant && w_reg != '0;
      if (|grant) begin
        write_reg  <= w_reg;
        write_data <= w_data;
      end
      // set is applied after clear so a same-edge reissue stays pending; bit 0 never pends
      r_pend <= ((r_pend & ~w_clr) | w_set) & ~NR'(1);
    end
  end
`ifndef WB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ptr <= '0;
    else if (|grant) r_ptr <= w_nxt;
  end
`endif
endmodule
